// File: rtl/rsa_if_pkg.sv
// Shared definitions for the RSA accelerator command protocol: command codes,
// response status codes and the initiator state encoding.
package rsa_if_pkg;

  localparam logic [31:0] CMD_LOAD     = 32'd0;
  localparam logic [31:0] CMD_EXP      = 32'd1;
  localparam logic [31:0] CMD_MONT     = 32'd3;
  localparam logic [31:0] CMD_READBACK = 32'd4;

  localparam logic [1:0] STATUS_OK      = 2'd0;
  localparam logic [1:0] STATUS_BAD_CMD = 2'd1;
  localparam logic [1:0] STATUS_TIMEOUT = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND_CMD  = 3'd1,
    ST_DATA_OUT  = 3'd2,
    ST_DATA_IN   = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_DONE_CLR  = 3'd5,
    ST_RESP      = 3'd6
  } init_state_e;

  function automatic logic cmd_is_valid(input logic [31:0] cmd);
    return (cmd == CMD_LOAD) || (cmd == CMD_EXP) ||
           (cmd == CMD_MONT) || (cmd == CMD_READBACK);
  endfunction

endpackage

// File: rtl/rsa_cmd_initiator_watchdog.sv
// rsa_watchdog: counts cycles while enabled; expired is high once the count
// shows TIMEOUT_CYCLES cycles spent since the last clear.
module rsa_watchdog #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  // Count saturates at LAST so expired stays asserted until the state changes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + W'(1);
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/rsa_cmd_initiator.sv
// rsa_cmd_initiator: runs one request through the wrapper cmd/data/done exchange
// and returns result + status. Define RSA_INIT_TIMEOUT_EN to add the wait-state watchdog.
module rsa_cmd_initiator
  import rsa_if_pkg::*;
#(
  parameter int TX_SIZE        = 1024,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [31:0]        req_cmd,
  input  logic [TX_SIZE-1:0] req_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [TX_SIZE-1:0] rsp_data,
  output logic [1:0]         rsp_status,
  output logic [31:0]        arm_to_fpga_cmd,
  output logic               arm_to_fpga_cmd_valid,
  output logic               arm_to_fpga_data_valid,
  input  logic               arm_to_fpga_data_ready,
  output logic [TX_SIZE-1:0] arm_to_fpga_data,
  input  logic               fpga_to_arm_data_valid,
  output logic               fpga_to_arm_data_ready,
  input  logic [TX_SIZE-1:0] fpga_to_arm_data,
  input  logic               fpga_to_arm_done,
  output logic               fpga_to_arm_done_read
);

  // Handshakes: a valid/ready pair transfers on every rising edge where both are
  // high; a valid side holds its payload stable until that edge. The cmd, inbound
  // data-ready and done_read signals are single-cycle strobes, not level handshakes.

  init_state_e state, state_next;
  logic [31:0]        cmd_q;
  logic [TX_SIZE-1:0] data_q;
  logic               accept;
  logic               timeout_hit;

  logic               req_ready_nxt, rsp_valid_nxt, cmd_valid_nxt;
  logic               data_valid_nxt, data_ready_nxt, done_read_nxt;
  logic [31:0]        cmd_nxt;
  logic [TX_SIZE-1:0] out_data_nxt, rsp_data_nxt;
  logic [1:0]         rsp_status_nxt;

  assign accept = (state == ST_IDLE) && req_valid;

`ifdef RSA_INIT_TIMEOUT_EN
  logic wd_enable;
  logic wd_clear;

  assign wd_enable = (state == ST_DATA_OUT) || (state == ST_DATA_IN) ||
                     (state == ST_WAIT_DONE) || (state == ST_DONE_CLR);
  assign wd_clear  = (state_next != state);

  rsa_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(timeout_hit)
  );
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  // State, request latch and all outputs share one register process.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                  <= ST_IDLE;
      cmd_q                  <= '0;
      data_q                 <= '0;
      req_ready              <= 1'b1;
      rsp_valid              <= 1'b0;
      rsp_data               <= '0;
      rsp_status             <= '0;
      arm_to_fpga_cmd        <= '0;
      arm_to_fpga_cmd_valid  <= 1'b0;
      arm_to_fpga_data_valid <= 1'b0;
      arm_to_fpga_data       <= '0;
      fpga_to_arm_data_ready <= 1'b0;
      fpga_to_arm_done_read  <= 1'b0;
    end else begin
      state                  <= state_next;
      if (accept) begin
        cmd_q  <= req_cmd;
        data_q <= req_data;
      end
      req_ready              <= req_ready_nxt;
      rsp_valid              <= rsp_valid_nxt;
      rsp_data               <= rsp_data_nxt;
      rsp_status             <= rsp_status_nxt;
      arm_to_fpga_cmd        <= cmd_nxt;
      arm_to_fpga_cmd_valid  <= cmd_valid_nxt;
      arm_to_fpga_data_valid <= data_valid_nxt;
      arm_to_fpga_data       <= out_data_nxt;
      fpga_to_arm_data_ready <= data_ready_nxt;
      fpga_to_arm_done_read  <= done_read_nxt;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:      if (req_valid) state_next = cmd_is_valid(req_cmd) ? ST_SEND_CMD : ST_RESP;
      ST_SEND_CMD: begin
        if (cmd_q == CMD_LOAD)          state_next = ST_DATA_OUT;
        else if (cmd_q == CMD_READBACK) state_next = ST_DATA_IN;
        else                            state_next = ST_WAIT_DONE;
      end
      ST_DATA_OUT:  if (arm_to_fpga_data_ready) state_next = ST_WAIT_DONE;
      ST_DATA_IN:   if (fpga_to_arm_data_valid) state_next = ST_WAIT_DONE;
      ST_WAIT_DONE: if (fpga_to_arm_done)       state_next = ST_DONE_CLR;
      // The wrapper's done lags done_read by a cycle; wait for it to fall.
      ST_DONE_CLR:  if (!fpga_to_arm_done)      state_next = ST_RESP;
      ST_RESP:      if (rsp_ready)              state_next = ST_IDLE;
      default:                                  state_next = ST_IDLE;
    endcase
    if (timeout_hit) state_next = ST_RESP;
  end

  // Next values of the registered outputs, derived from the transition taken.
  always_comb begin
    req_ready_nxt  = (state_next == ST_IDLE);
    rsp_valid_nxt  = (state_next == ST_RESP);
    cmd_valid_nxt  = (state_next == ST_SEND_CMD);
    data_valid_nxt = (state_next == ST_DATA_OUT);
    data_ready_nxt = (state == ST_DATA_IN) && (state_next == ST_WAIT_DONE);
    done_read_nxt  = (state == ST_WAIT_DONE) && (state_next == ST_DONE_CLR);

    cmd_nxt        = arm_to_fpga_cmd;
    out_data_nxt   = arm_to_fpga_data;
    rsp_data_nxt   = rsp_data;
    rsp_status_nxt = rsp_status;

    if (accept) begin
      cmd_nxt        = cmd_is_valid(req_cmd) ? req_cmd : '0;
      rsp_data_nxt   = '0;
      rsp_status_nxt = cmd_is_valid(req_cmd) ? STATUS_OK : STATUS_BAD_CMD;
    end
    if ((state == ST_SEND_CMD) && (state_next == ST_DATA_OUT)) out_data_nxt = data_q;
    if (data_ready_nxt) rsp_data_nxt = fpga_to_arm_data;
    if (timeout_hit) begin
      rsp_data_nxt   = '0;
      rsp_status_nxt = STATUS_TIMEOUT;
    end
  end

endmodule

// File: tb/tb_rsa_cmd_initiator.sv
// Bench for rsa_cmd_initiator: table of request records run against a reactive
// wrapper model, a response scoreboard, plus a hand-written mid-transfer reset.
module tb_rsa_cmd_initiator;

  localparam int TX_SIZE = 1024;
  localparam int TMO     = 16;

  localparam logic [31:0] C_LOAD = 32'd0;
  localparam logic [31:0] C_EXP  = 32'd1;
  localparam logic [31:0] C_MONT = 32'd3;
  localparam logic [31:0] C_RB   = 32'd4;

  typedef struct {
    logic [31:0]        cmd;
    logic [TX_SIZE-1:0] data;
    logic [TX_SIZE-1:0] rb_data;
    int                 ready_dly;
    int                 valid_dly;
    int                 done_dly;
    int                 rsp_hold;
    bit                 noise;
    int                 lat_max;
    int                 lat_exact;
    logic [1:0]         exp_status;
    logic [TX_SIZE-1:0] exp_data;
  } vec_t;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               req_valid = 1'b0;
  logic               req_ready;
  logic [31:0]        req_cmd = '0;
  logic [TX_SIZE-1:0] req_data = '0;
  logic               rsp_valid;
  logic               rsp_ready = 1'b0;
  logic [TX_SIZE-1:0] rsp_data;
  logic [1:0]         rsp_status;
  logic [31:0]        arm_to_fpga_cmd;
  logic               arm_to_fpga_cmd_valid;
  logic               arm_to_fpga_data_valid;
  logic               arm_to_fpga_data_ready = 1'b0;
  logic [TX_SIZE-1:0] arm_to_fpga_data;
  logic               fpga_to_arm_data_valid = 1'b0;
  logic               fpga_to_arm_data_ready;
  logic [TX_SIZE-1:0] fpga_to_arm_data = '0;
  logic               fpga_to_arm_done = 1'b0;
  logic               fpga_to_arm_done_read;

  int tests_run = 0;
  int tests_failed = 0;
  int cur_row = -1;
  logic [TX_SIZE+1:0] exp_q[$];
  vec_t vecs[$];

  rsa_cmd_initiator #(.TX_SIZE(TX_SIZE), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_status(rsp_status),
    .arm_to_fpga_cmd(arm_to_fpga_cmd), .arm_to_fpga_cmd_valid(arm_to_fpga_cmd_valid),
    .arm_to_fpga_data_valid(arm_to_fpga_data_valid), .arm_to_fpga_data_ready(arm_to_fpga_data_ready),
    .arm_to_fpga_data(arm_to_fpga_data),
    .fpga_to_arm_data_valid(fpga_to_arm_data_valid), .fpga_to_arm_data_ready(fpga_to_arm_data_ready),
    .fpga_to_arm_data(fpga_to_arm_data),
    .fpga_to_arm_done(fpga_to_arm_done), .fpga_to_arm_done_read(fpga_to_arm_done_read)
  );

  // Clock / global time limit
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: got no summary, want completion before time limit");
    $fatal(1, "bench time limit");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s (row %0d): got %0h want %0h", name, cur_row, act, exp);
    end
  endtask

  task automatic check_wide(input string name, input logic [TX_SIZE-1:0] act,
                            input logic [TX_SIZE-1:0] exp);
    int idx;
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      idx = -1;
      for (int i = 0; i < TX_SIZE; i++) if (idx < 0 && act[i] !== exp[i]) idx = i;
      $display("FAIL %s (row %0d): got low128 %0h want low128 %0h, first diff bit %0d",
               name, cur_row, act[127:0], exp[127:0], idx);
    end
  endtask

  function automatic logic [TX_SIZE-1:0] rand_wide();
    logic [TX_SIZE-1:0] r;
    for (int i = 0; i < TX_SIZE / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic vec_t mk(input logic [31:0] cmd, input logic [TX_SIZE-1:0] data,
                              input logic [TX_SIZE-1:0] rb, input int rdly, input int vdly,
                              input int ddly, input int hold, input bit noise,
                              input int lmax, input int lexact, input logic [1:0] st,
                              input logic [TX_SIZE-1:0] ed);
    vec_t v;
    v.cmd = cmd; v.data = data; v.rb_data = rb; v.ready_dly = rdly; v.valid_dly = vdly;
    v.done_dly = ddly; v.rsp_hold = hold; v.noise = noise; v.lat_max = lmax;
    v.lat_exact = lexact; v.exp_status = st; v.exp_data = ed;
    return v;
  endfunction

  // Driver + reactive wrapper model for one request, then scoreboard compare.
  task automatic run_vec(input vec_t v);
    int cyc, dv_age, in_cnt, wait_cnt, n_cmd, n_dv, n_dr, n_dn, exp_dv;
    bit armed, dr_seen, drop_pending, done_over, got;
    logic [TX_SIZE+1:0] e;
    logic [1:0] e_status;
    logic [TX_SIZE-1:0] e_data;
    dv_age = 0; in_cnt = 0; wait_cnt = 0; n_cmd = 0; n_dv = 0; n_dr = 0; n_dn = 0;
    armed = 0; dr_seen = 0; drop_pending = 0; done_over = 0; got = 0;
    fpga_to_arm_data = rand_wide();
    exp_q.push_back({v.exp_status, v.exp_data});
    check("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_cmd = v.cmd; req_data = v.data;
    @(negedge clk);
    req_valid = 1'b0; req_cmd = $urandom; req_data = rand_wide();
    for (cyc = 0; cyc < 3000; cyc++) begin
      if (arm_to_fpga_cmd_valid) begin
        n_cmd++;
        check("cmd_value", 64'(arm_to_fpga_cmd), 64'(v.cmd));
        if (v.cmd == C_EXP || v.cmd == C_MONT) begin armed = 1; wait_cnt = 0; end
      end
      if (arm_to_fpga_data_valid) begin
        n_dv++; dv_age++;
        check_wide("out_data_held", arm_to_fpga_data, v.data);
        arm_to_fpga_data_ready = (dv_age > v.ready_dly);
      end else begin
        if (v.cmd == C_LOAD && arm_to_fpga_data_ready) begin armed = 1; wait_cnt = 0; end
        arm_to_fpga_data_ready = (v.noise && v.cmd != C_LOAD) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (fpga_to_arm_data_ready) begin
        n_dr++; dr_seen = 1; armed = 1; wait_cnt = 0;
        fpga_to_arm_data_valid = 1'b0; fpga_to_arm_data = rand_wide();
      end else if (v.cmd == C_RB) begin
        if (n_cmd > 0 && !dr_seen) begin
          if (in_cnt >= v.valid_dly) begin
            fpga_to_arm_data_valid = 1'b1; fpga_to_arm_data = v.rb_data;
          end else begin
            fpga_to_arm_data = rand_wide();
          end
          in_cnt++;
        end
      end else if (v.noise) begin
        fpga_to_arm_data_valid = 1'($urandom_range(0, 1)); fpga_to_arm_data = rand_wide();
      end
      if (fpga_to_arm_done_read) begin
        n_dn++; drop_pending = 1;
      end else if (drop_pending) begin
        fpga_to_arm_done = 1'b0; drop_pending = 0; done_over = 1;
      end
      if (armed && !done_over && !fpga_to_arm_done && v.done_dly >= 0) begin
        if (wait_cnt >= v.done_dly) fpga_to_arm_done = 1'b1;
        wait_cnt++;
      end
      if (rsp_valid) begin got = 1; break; end
      @(negedge clk);
    end
    arm_to_fpga_data_ready = 1'b0; fpga_to_arm_data_valid = 1'b0; fpga_to_arm_done = 1'b0;
    check("rsp_seen_in_budget", 64'(got), 64'd1);
    check("sb_depth", 64'(exp_q.size()), 64'd1);
    e = '0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    e_status = e[TX_SIZE+1:TX_SIZE];
    e_data = e[TX_SIZE-1:0];
    check("rsp_status", 64'(rsp_status), 64'(e_status));
    check_wide("rsp_data", rsp_data, e_data);
    check("cmd_pulses", 64'(n_cmd), (v.exp_status == 2'd1) ? 64'd0 : 64'd1);
    exp_dv = (v.cmd == C_LOAD && v.exp_status == 2'd0) ? v.ready_dly + 1 : 0;
    check("out_valid_cycles", 64'(n_dv), 64'(exp_dv));
    check("in_ready_pulses", 64'(n_dr), (v.cmd == C_RB && v.exp_status == 2'd0) ? 64'd1 : 64'd0);
    check("done_read_pulses", 64'(n_dn), (v.exp_status == 2'd0) ? 64'd1 : 64'd0);
    if (v.lat_max >= 0) check("latency_max", 64'(cyc <= v.lat_max), 64'd1);
    if (v.lat_exact >= 0) check("latency_exact", 64'(cyc), 64'(v.lat_exact));
    for (int i = 0; i < v.rsp_hold; i++) begin
      @(negedge clk);
      fpga_to_arm_data = rand_wide();
      check("rsp_hold_valid", 64'(rsp_valid), 64'd1);
      check("rsp_hold_status", 64'(rsp_status), 64'(e_status));
      check_wide("rsp_hold_data", rsp_data, e_data);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_after_accept", 64'(rsp_valid), 64'd0);
    check("req_ready_after_accept", 64'(req_ready), 64'd1);
  endtask

  initial begin
    logic [TX_SIZE-1:0] a5, rb;
    bit seen;
    a5 = {128{8'hA5}};
    rb = rand_wide();
    // cmd, data, rb_data, ready_dly, valid_dly, done_dly, hold, noise, lat_max, lat_exact, status, rsp_data
    vecs.push_back(mk(C_LOAD, a5, '0, 2, 0, 1, 0, 0, -1, -1, 2'd0, '0));
    vecs.push_back(mk(C_RB, '0, 1024'h1234, 0, 3, 1, 0, 0, -1, -1, 2'd0, 1024'h1234));
    vecs.push_back(mk(C_EXP, rand_wide(), '0, 0, 0, 50, 5, 0, -1, -1, 2'd0, '0));
    vecs.push_back(mk(32'd2, rand_wide(), '0, 0, 0, 0, 0, 0, 2, -1, 2'd1, '0));
    vecs.push_back(mk(C_MONT, '0, '0, 0, 0, 4, 1, 1, -1, -1, 2'd0, '0));
    vecs.push_back(mk(C_LOAD, rand_wide(), '0, 0, 0, 0, 0, 0, 7, -1, 2'd0, '0));
    vecs.push_back(mk(C_RB, '0, rb, 0, 0, 2, 2, 0, -1, -1, 2'd0, rb));
    vecs.push_back(mk(32'hFFFF_FFFF, '0, '0, 0, 0, 0, 1, 0, 2, -1, 2'd1, '0));
    vecs.push_back(mk(C_LOAD, rand_wide(), '0, $urandom_range(0, 4), 0, 2, 0, 1, -1, -1, 2'd0, '0));
`ifdef RSA_INIT_TIMEOUT_EN
    vecs.push_back(mk(C_MONT, '0, '0, 0, 0, -1, 0, 0, -1, 17, 2'd2, '0));
    vecs.push_back(mk(C_LOAD, a5, '0, 1, 0, 0, 0, 0, -1, -1, 2'd0, '0));
`endif

    // Reset phase
    repeat (3) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_cmd_valid", 64'(arm_to_fpga_cmd_valid), 64'd0);
    check("rst_data_valid", 64'(arm_to_fpga_data_valid), 64'd0);
    check("rst_in_ready", 64'(fpga_to_arm_data_ready), 64'd0);
    check("rst_done_read", 64'(fpga_to_arm_done_read), 64'd0);
    check("rst_rsp_status", 64'(rsp_status), 64'd0);
    check("rst_cmd", 64'(arm_to_fpga_cmd), 64'd0);
    check_wide("rst_rsp_data", rsp_data, '0);
    check_wide("rst_out_data", arm_to_fpga_data, '0);
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[r]) begin
      cur_row = r;
      run_vec(vecs[r]);
    end

    // Asynchronous reset in the middle of an outbound data transfer
    cur_row = 100;
    req_valid = 1'b1; req_cmd = C_LOAD; req_data = rand_wide();
    @(negedge clk);
    req_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (arm_to_fpga_data_valid) begin seen = 1; break; end
      @(negedge clk);
    end
    check("mid_reset_reached_data_out", 64'(seen), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_reset_data_valid", 64'(arm_to_fpga_data_valid), 64'd0);
    check("mid_reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid_reset_req_ready", 64'(req_ready), 64'd1);
    check("mid_reset_cmd_valid", 64'(arm_to_fpga_cmd_valid), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    cur_row = 101;
    run_vec(mk(C_LOAD, a5, '0, 1, 0, 1, 0, 0, 7, -1, 2'd0, '0));

    check("sb_empty_at_end", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
